// File: rtl/sbox_share_scheduler_if.sv
// Request/response handshake bundle between the masked S-box scheduler and its
// two requesters (round datapath and key schedule).
interface sbox_share_scheduler_if #(
  parameter int DTAG_W = 4,
  parameter int KTAG_W = 2
);
  logic              req_d_valid;
  logic [15:0]       req_d_data;
  logic [DTAG_W-1:0] req_d_tag;
  logic              req_d_ready;

  logic              req_k_valid;
  logic [15:0]       req_k_data;
  logic [KTAG_W-1:0] req_k_tag;
  logic              req_k_ready;

  logic              rsp_d_valid;
  logic              rsp_k_valid;
  logic [15:0]       rsp_data;
  logic [DTAG_W-1:0] rsp_tag;

  modport master (
    output req_d_valid, req_d_data, req_d_tag,
    input  req_d_ready,
    output req_k_valid, req_k_data, req_k_tag,
    input  req_k_ready,
    input  rsp_d_valid, rsp_k_valid, rsp_data, rsp_tag
  );

  modport slave (
    input  req_d_valid, req_d_data, req_d_tag,
    output req_d_ready,
    input  req_k_valid, req_k_data, req_k_tag,
    output req_k_ready,
    output rsp_d_valid, rsp_k_valid, rsp_data, rsp_tag
  );
endinterface

// File: rtl/sbox_share_scheduler.sv
// Shares one pipelined first-order masked AES S-box between the round datapath
// and the key schedule; a shadow pipeline routes each result back to its owner.
module sbox_share_scheduler #(
  parameter int SBOX_LAT = 6,
  parameter int DTAG_W   = 4,
  parameter int KTAG_W   = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush,
  input  logic                              prng_valid,
  sbox_share_scheduler_if.slave             bus,
  output logic [15:0]                       sbox_in,
  input  logic [15:0]                       sbox_out,
  output logic [$clog2(SBOX_LAT+1)-1:0]     inflight_cnt,
  output logic                              idle
);

  localparam int CNT_W = $clog2(SBOX_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {
    OWN_D = 1'b0,
    OWN_K = 1'b1
  } owner_t;

  owner_t              last_grant;
  owner_t              grant;
  logic                can_issue;
  logic                issue;
  logic                pipe_exit;
  logic [DTAG_W-1:0]   issue_tag;

  logic [SBOX_LAT-1:0] sh_valid;
  owner_t              sh_owner [SBOX_LAT];
  logic [DTAG_W-1:0]   sh_tag   [SBOX_LAT];

  // Round-robin: on a tie the requester that did not win last time goes first.
  always_comb begin
    can_issue = prng_valid & ~flush & rst_n;
    grant     = OWN_D;
    if (bus.req_d_valid && bus.req_k_valid) begin
      grant = (last_grant == OWN_K) ? OWN_D : OWN_K;
    end else if (bus.req_k_valid) begin
      grant = OWN_K;
    end
    issue           = can_issue & (bus.req_d_valid | bus.req_k_valid);
    bus.req_d_ready = can_issue & bus.req_d_valid & (grant == OWN_D);
    bus.req_k_ready = can_issue & bus.req_k_valid & (grant == OWN_K);
    issue_tag       = (grant == OWN_D) ? bus.req_d_tag : DTAG_W'(bus.req_k_tag);
    // Zero shares when idle so a stale masked value is never re-presented.
    sbox_in = '0;
    if (issue) begin
      sbox_in = (grant == OWN_D) ? bus.req_d_data : bus.req_k_data;
    end
  end

  assign pipe_exit = sh_valid[SBOX_LAT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant   <= OWN_K;
      sh_valid     <= '0;
      inflight_cnt <= '0;
      for (int unsigned i = 0; i < SBOX_LAT; i++) begin
        sh_owner[i] <= OWN_D;
        sh_tag[i]   <= '0;
      end
    end else begin
      if (issue) begin
        last_grant <= grant;
      end
      sh_valid    <= flush ? '0 : {sh_valid[SBOX_LAT-2:0], issue};
      sh_owner[0] <= grant;
      sh_tag[0]   <= issue_tag;
      for (int unsigned i = 1; i < SBOX_LAT; i++) begin
        sh_owner[i] <= sh_owner[i-1];
        sh_tag[i]   <= sh_tag[i-1];
      end
      if (flush) begin
        inflight_cnt <= '0;
      end else if (issue && !pipe_exit) begin
        inflight_cnt <= inflight_cnt + CNT_ONE;
      end else if (!issue && pipe_exit) begin
        inflight_cnt <= inflight_cnt - CNT_ONE;
      end
    end
  end

  assign bus.rsp_d_valid = pipe_exit & (sh_owner[SBOX_LAT-1] == OWN_D);
  assign bus.rsp_k_valid = pipe_exit & (sh_owner[SBOX_LAT-1] == OWN_K);
  assign bus.rsp_data    = sbox_out;
  assign bus.rsp_tag     = sh_tag[SBOX_LAT-1];
  assign idle            = (inflight_cnt == '0) & ~bus.req_d_valid & ~bus.req_k_valid;

endmodule

// File: tb/tb_sbox_share_scheduler.sv
// Bench for sbox_share_scheduler: a behavioural masked S-box drives sbox_out and a
// scoreboard of {owner, tag, unmasked value, due cycle} follows every issue.
module tb_sbox_share_scheduler;
  localparam int LAT = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        prng_valid = 1'b0;
  logic [15:0] sbox_in;
  logic [15:0] sbox_out;
  logic [2:0]  inflight_cnt;
  logic        idle;

  sbox_share_scheduler_if #(.DTAG_W(4), .KTAG_W(2)) bus ();

  sbox_share_scheduler #(.SBOX_LAT(LAT), .DTAG_W(4), .KTAG_W(2)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .prng_valid   (prng_valid),
    .bus          (bus),
    .sbox_in      (sbox_in),
    .sbox_out     (sbox_out),
    .inflight_cnt (inflight_cnt),
    .idle         (idle)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int unsigned cyc = 0;
  bit          mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rol8(input logic [7:0] v, input int k);
    return (v << k) | (v >> (8 - k));
  endfunction

  function automatic logic [7:0] aes_sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    return inv ^ rol8(inv, 1) ^ rol8(inv, 2) ^ rol8(inv, 3) ^ rol8(inv, 4) ^ 8'h63;
  endfunction

  // Behavioural masked S-box: output {mask, sbox(x)^mask}, fresh mask per byte.
  logic [15:0] spipe [LAT];
  always @(posedge clk) begin
    logic [7:0] m;
    m = 8'($urandom);
    for (int i = LAT - 1; i > 0; i--) spipe[i] <= spipe[i-1];
    spipe[0] <= {m, aes_sbox(sbox_in[15:8] ^ sbox_in[7:0]) ^ m};
  end
  assign sbox_out = spipe[LAT-1];

  typedef struct {
    logic        own;
    logic [3:0]  tag;
    logic [7:0]  val;
    int unsigned due;
  } exp_t;

  exp_t        sb[$];
  exp_t        h;
  logic        m_last;
  logic        g, ed, ek, exp_idle;
  logic [15:0] gdata;

  always @(negedge clk) if (mon_en) begin
    if (!rst_n) begin
      sb.delete();
      m_last = 1'b1;
      n_cmp++;
      if ({bus.rsp_d_valid, bus.rsp_k_valid, bus.req_d_ready, bus.req_k_ready} !== 4'b0000) begin
        n_err++;
        $display("FAIL reset_outputs: got %b expected 0000",
                 {bus.rsp_d_valid, bus.rsp_k_valid, bus.req_d_ready, bus.req_k_ready});
      end
      n_cmp++;
      if (inflight_cnt !== 3'd0) begin
        n_err++;
        $display("FAIL reset_inflight: got %0d expected 0", inflight_cnt);
      end
    end else begin
      n_cmp++;
      if (int'(inflight_cnt) !== sb.size()) begin
        n_err++;
        $display("FAIL inflight_cnt: cycle %0d got %0d expected %0d", cyc, inflight_cnt, sb.size());
      end
      exp_idle = (sb.size() == 0) && !bus.req_d_valid && !bus.req_k_valid;
      n_cmp++;
      if (idle !== exp_idle) begin
        n_err++;
        $display("FAIL idle: cycle %0d got %b expected %b", cyc, idle, exp_idle);
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
        h = sb.pop_front();
        n_cmp++;
        if ({bus.rsp_d_valid, bus.rsp_k_valid} !== {~h.own, h.own} || bus.rsp_tag !== h.tag) begin
          n_err++;
          $display("FAIL rsp_owner_tag: cycle %0d got d=%b k=%b tag=%0d expected d=%b k=%b tag=%0d",
                   cyc, bus.rsp_d_valid, bus.rsp_k_valid, bus.rsp_tag, ~h.own, h.own, h.tag);
        end
        n_cmp++;
        if ((bus.rsp_data[15:8] ^ bus.rsp_data[7:0]) !== h.val) begin
          n_err++;
          $display("FAIL rsp_value: cycle %0d got %h expected %h",
                   cyc, bus.rsp_data[15:8] ^ bus.rsp_data[7:0], h.val);
        end
      end else begin
        n_cmp++;
        if ({bus.rsp_d_valid, bus.rsp_k_valid} !== 2'b00) begin
          n_err++;
          $display("FAIL rsp_spurious: cycle %0d got d=%b k=%b expected none",
                   cyc, bus.rsp_d_valid, bus.rsp_k_valid);
        end
      end
      n_cmp++;
      if (bus.rsp_data !== sbox_out) begin
        n_err++;
        $display("FAIL rsp_data_pass: got %h expected %h", bus.rsp_data, sbox_out);
      end
      if (flush) sb.delete();
      // Reference arbiter: 1 = key schedule, 0 = datapath.
      if (bus.req_d_valid && bus.req_k_valid) g = ~m_last;
      else g = bus.req_k_valid;
      ed = prng_valid && !flush && bus.req_d_valid && !g;
      ek = prng_valid && !flush && bus.req_k_valid && g;
      n_cmp++;
      if ({bus.req_d_ready, bus.req_k_ready} !== {ed, ek}) begin
        n_err++;
        $display("FAIL ready: cycle %0d got d=%b k=%b expected d=%b k=%b",
                 cyc, bus.req_d_ready, bus.req_k_ready, ed, ek);
      end
      gdata = g ? bus.req_k_data : bus.req_d_data;
      if (ed || ek) begin
        sb.push_back('{own: g, tag: g ? {2'b00, bus.req_k_tag} : bus.req_d_tag,
                       val: aes_sbox(gdata[15:8] ^ gdata[7:0]), due: cyc + LAT});
        m_last = g;
      end else begin
        gdata = 16'h0000;
      end
      n_cmp++;
      if (sbox_in !== gdata) begin
        n_err++;
        $display("FAIL sbox_in: cycle %0d got %h expected %h", cyc, sbox_in, gdata);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    bus.req_d_valid = 1'b0;
    bus.req_k_valid = 1'b0;
  endtask

  task automatic test_reset();
    clear_reqs();
    bus.req_d_data = '0; bus.req_d_tag = '0;
    bus.req_k_data = '0; bus.req_k_tag = '0;
    prng_valid = 1'b1;
    #2 rst_n = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (idle !== 1'b1 || inflight_cnt !== 3'd0 || bus.rsp_tag !== 4'd0) begin
      n_err++;
      $display("FAIL reset_state: got idle=%b cnt=%0d tag=%0d expected 1/0/0", idle, inflight_cnt, bus.rsp_tag);
    end
    tick();
    bus.req_d_valid = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.req_d_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ready: got %b expected 0", bus.req_d_ready);
    end
    tick();
    clear_reqs();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_contention();
    logic [3:0] dt;
    logic [1:0] kt;
    dt = 4'd0; kt = 2'd0;
    prng_valid = 1'b1;
    bus.req_d_valid = 1'b1; bus.req_d_data = 16'h0000; bus.req_d_tag = dt;
    bus.req_k_valid = 1'b1; bus.req_k_data = 16'hAAAA; bus.req_k_tag = kt;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.req_d_ready, bus.req_k_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        n_err++;
        $display("FAIL contention_grant: step %0d got d=%b k=%b", i, bus.req_d_ready, bus.req_k_ready);
      end
      if (i == 6) begin
        n_cmp++;
        if (bus.rsp_d_valid !== 1'b1 || bus.rsp_tag !== 4'd0 ||
            (bus.rsp_data[15:8] ^ bus.rsp_data[7:0]) !== 8'h63) begin
          n_err++;
          $display("FAIL contention_first_d: got v=%b tag=%0d val=%h expected 1/0/63",
                   bus.rsp_d_valid, bus.rsp_tag, bus.rsp_data[15:8] ^ bus.rsp_data[7:0]);
        end
      end
      if (i == 7) begin
        n_cmp++;
        if (bus.rsp_k_valid !== 1'b1 || bus.rsp_tag !== 4'd0) begin
          n_err++;
          $display("FAIL contention_first_k: got v=%b tag=%0d expected 1/0", bus.rsp_k_valid, bus.rsp_tag);
        end
      end
      tick();
      if (i % 2 == 0) dt = dt + 4'd1;
      else kt = kt + 2'd1;
      bus.req_d_tag = dt;
      bus.req_k_tag = kt;
    end
    clear_reqs();
    repeat (LAT + 2) tick();
  endtask

  task automatic test_single_d();
    prng_valid = 1'b1;
    bus.req_d_valid = 1'b1; bus.req_d_data = 16'h5300; bus.req_d_tag = 4'd5;
    @(negedge clk);
    n_cmp++;
    if (bus.req_d_ready !== 1'b1 || sbox_in !== 16'h5300) begin
      n_err++;
      $display("FAIL single_issue: got ready=%b sbox_in=%h expected 1/5300", bus.req_d_ready, sbox_in);
    end
    tick();
    clear_reqs();
    repeat (5) tick();
    @(negedge clk);
    n_cmp++;
    if (bus.rsp_d_valid !== 1'b1 || bus.rsp_tag !== 4'd5 ||
        (bus.rsp_data[15:8] ^ bus.rsp_data[7:0]) !== 8'hED) begin
      n_err++;
      $display("FAIL single_rsp: got v=%b tag=%0d val=%h expected 1/5/ed",
               bus.rsp_d_valid, bus.rsp_tag, bus.rsp_data[15:8] ^ bus.rsp_data[7:0]);
    end
    repeat (2) tick();
  endtask

  task automatic test_prng_gap();
    prng_valid = 1'b0;
    bus.req_d_valid = 1'b1; bus.req_d_data = 16'h1234; bus.req_d_tag = 4'd9;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.req_d_ready !== 1'b0 || sbox_in !== 16'h0000) begin
        n_err++;
        $display("FAIL prng_gap_hold: step %0d got ready=%b sbox_in=%h expected 0/0000", i, bus.req_d_ready, sbox_in);
      end
      tick();
    end
    prng_valid = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.req_d_ready !== 1'b1) begin
      n_err++;
      $display("FAIL prng_gap_issue: got %b expected 1", bus.req_d_ready);
    end
    tick();
    clear_reqs();
    repeat (5) tick();
    @(negedge clk);
    n_cmp++;
    if (bus.rsp_d_valid !== 1'b1 || bus.rsp_tag !== 4'd9) begin
      n_err++;
      $display("FAIL prng_gap_rsp: got v=%b tag=%0d expected 1/9", bus.rsp_d_valid, bus.rsp_tag);
    end
    repeat (2) tick();
  endtask

  task automatic test_flush();
    prng_valid = 1'b1;
    bus.req_k_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.req_k_tag = 2'(i);
      bus.req_k_data = 16'($urandom);
      @(negedge clk);
      n_cmp++;
      if (bus.req_k_ready !== 1'b1) begin
        n_err++;
        $display("FAIL flush_k_issue: step %0d got %b expected 1", i, bus.req_k_ready);
      end
      tick();
    end
    clear_reqs();
    tick();
    flush = 1'b1;
    bus.req_d_valid = 1'b1; bus.req_d_data = 16'h0102; bus.req_d_tag = 4'd3;
    @(negedge clk);
    n_cmp++;
    if (bus.req_d_ready !== 1'b0 || inflight_cnt !== 3'd4) begin
      n_err++;
      $display("FAIL flush_cycle: got ready=%b cnt=%0d expected 0/4", bus.req_d_ready, inflight_cnt);
    end
    tick();
    flush = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.req_d_ready !== 1'b1 || inflight_cnt !== 3'd0) begin
      n_err++;
      $display("FAIL flush_after: got ready=%b cnt=%0d expected 1/0", bus.req_d_ready, inflight_cnt);
    end
    tick();
    clear_reqs();
    for (int j = 7; j <= 12; j++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.rsp_k_valid !== 1'b0) begin
        n_err++;
        $display("FAIL flush_killed_k: cycle %0d got %b expected 0", j, bus.rsp_k_valid);
      end
      if (j == 12) begin
        n_cmp++;
        if (bus.rsp_d_valid !== 1'b1 || bus.rsp_tag !== 4'd3) begin
          n_err++;
          $display("FAIL flush_new_d: got v=%b tag=%0d expected 1/3", bus.rsp_d_valid, bus.rsp_tag);
        end
      end else begin
        tick();
      end
    end
    repeat (2) tick();
  endtask

  task automatic test_reset_midstream();
    prng_valid = 1'b1;
    bus.req_d_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.req_d_tag = 4'(10 + i);
      bus.req_d_data = 16'($urandom);
      tick();
    end
    clear_reqs();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.rsp_d_valid, bus.rsp_k_valid} !== 2'b00 || inflight_cnt !== 3'd0 || idle !== 1'b1) begin
      n_err++;
      $display("FAIL midstream_reset: got d=%b k=%b cnt=%0d idle=%b expected 0/0/0/1",
               bus.rsp_d_valid, bus.rsp_k_valid, inflight_cnt, idle);
    end
    tick();
    rst_n = 1'b1;
    bus.req_d_valid = 1'b1; bus.req_d_tag = 4'd1;
    bus.req_k_valid = 1'b1; bus.req_k_tag = 2'd2;
    @(negedge clk);
    n_cmp++;
    if ({bus.req_d_ready, bus.req_k_ready} !== 2'b10) begin
      n_err++;
      $display("FAIL midstream_tie: got d=%b k=%b expected d=1 k=0", bus.req_d_ready, bus.req_k_ready);
    end
    tick();
    clear_reqs();
    repeat (LAT + 2) tick();
  endtask

  task automatic test_random();
    logic rd, rk;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      rd = bus.req_d_ready;
      rk = bus.req_k_ready;
      tick();
      prng_valid = ($urandom_range(0, 9) < 7);
      if (!bus.req_d_valid || rd) begin
        bus.req_d_valid = ($urandom_range(0, 2) != 0);
        bus.req_d_data  = 16'($urandom);
        bus.req_d_tag   = 4'($urandom);
      end
      if (!bus.req_k_valid || rk) begin
        bus.req_k_valid = ($urandom_range(0, 2) != 0);
        bus.req_k_data  = 16'($urandom);
        bus.req_k_tag   = 2'($urandom);
      end
    end
    @(negedge clk);
    tick();
    clear_reqs();
    prng_valid = 1'b0;
    repeat (LAT + 2) tick();
    @(negedge clk);
    n_cmp++;
    if (sb.size() !== 0) begin
      n_err++;
      $display("FAIL random_drain: got %0d outstanding expected 0", sb.size());
    end
  endtask

  initial begin
    bus.req_d_valid = 1'b0;
    bus.req_k_valid = 1'b0;
    test_reset();
    test_contention();
    test_single_d();
    test_prng_gap();
    test_flush();
    test_reset_midstream();
    test_random();
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sbox_share_scheduler.md
Name: sbox_share_scheduler

Overview:
- Time-multiplexes one first-order masked AES S-box between two requesters: the round datapath (SubBytes, 16 bytes/round) and the key schedule (SubWord, 4 bytes/round).
- Gates issue on availability of fresh randomness and arbitrates between the two requesters.
- Tracks owner and tag of every in-flight byte through a shadow pipeline matched to the S-box latency.
- Returns results to the correct requester.

Parameters:
- SBOX_LAT, 6: issue-to-result latency of the shared S-box in cycles; fully pipelined, 1 byte/cycle.
- DTAG_W, 4: datapath tag width (state byte index 0..15).
- KTAG_W, 2: key-schedule tag width (word byte index 0..3).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous abort; kills all in-flight entries
- prng_valid  in  1  20 fresh random bits are available this cycle for the S-box
- req_d_valid  in  1  datapath request
- req_d_data  in  16  datapath Boolean shares {share1, share0}
- req_d_tag  in  DTAG_W  datapath byte index
- req_d_ready  out  1  datapath request accepted this cycle
- req_k_valid  in  1  key-schedule request
- req_k_data  in  16  key-schedule shares {share1, share0}
- req_k_tag  in  KTAG_W  key-schedule byte index
- req_k_ready  out  1  key-schedule request accepted this cycle
- sbox_in  out  16  to S-box input (combinational mux)
- sbox_out  in  16  from S-box output
- rsp_d_valid  out  1  result for datapath
- rsp_k_valid  out  1  result for key schedule
- rsp_data  out  16  = sbox_out, shares {share1, share0}
- rsp_tag  out  DTAG_W  tag of the returned byte; key tags zero-extended
- inflight_cnt  out  clog2(SBOX_LAT+1)  number of valid shadow stages
- idle  out  1  inflight_cnt==0 and no request valid

Behaviour:
- Reset (rst_n low, async):
  - All shadow valids clear; last_grant=K, so the datapath wins the first tie.
  - Outputs: rsp_*_valid=0, rsp_data=sbox_out passthrough, rsp_tag=0, inflight_cnt=0, idle=1, ready=0.
- Issue condition: can_issue = prng_valid & ~flush & rst_n.
- Arbiter (2-state round-robin, state last_grant ∈ {D,K}):
  - Only D valid: grant D.
  - Only K valid: grant K.
  - Both valid: grant the requester that is not last_grant.
  - last_grant updates only on an actual issue.
  - Ready is asserted only for the granted requester and only when can_issue; valid&ready = issue.
  - A request must hold data/tag stable until ready.
- sbox_in:
  - Granted request's data when issuing.
  - Otherwise 16'h0000. Stale shares are never re-presented.
- Shadow pipeline: SBOX_LAT stages of {valid, owner, tag}.
  - Stage 0 is written on every edge with {issue, grant, tag}.
  - Shifts every cycle, no stall.
  - Issue at edge t -> rsp_*_valid high in cycle t+SBOX_LAT, with rsp_tag of that issue, for exactly one cycle.
  - Responses have no backpressure; consumers must accept.
  - rsp_d_valid = last.valid & owner==D; rsp_k_valid = last.valid & owner==K; never both.
- Throughput: one issue per cycle whenever prng_valid is held high, alternating under contention.
- prng_valid low: no issue. Requests wait; the pipeline keeps draining and the resulting bubbles appear at the output SBOX_LAT cycles later.
- flush: on that edge all shadow valids clear and no issue occurs. The S-box still computes, but results are never flagged valid. last_grant is held.
- inflight_cnt: up/down counter tracking issues in and valid exits out; equals the popcount of shadow valids at all times. Reset to 0 by flush.
- Simultaneous issue and exit: the count is unchanged.

Test Plan:
- Single D request, data 16'h5300, tag 5, prng_valid=1 -> req_d_ready same cycle; 6 cycles later rsp_d_valid=1, rsp_tag=5, rsp_data[15:8]^rsp_data[7:0]=8'hED.
- Both valid continuously for 8 cycles (D data 16'h0000, K data 16'hAAAA) -> grants D,K,D,K,...; responses alternate D,K from cycle 6 with matching tags; unmasked D result = 8'h63.
- Single D request with prng_valid low for 3 cycles -> no ready, sbox_in=0; issue on cycle 3 when prng_valid rises; response at cycle 9.
- 4 back-to-back K issues, flush asserted 2 cycles later -> no rsp_k_valid ever; inflight_cnt=0 after flush; a new D issue next cycle returns normally 6 cycles later.
- rst_n pulsed low mid-stream with 5 in flight -> immediate rsp_*_valid=0, inflight_cnt=0, idle=1; after release, first tie grants D.
- Random stream of issues with random prng_valid gaps -> inflight_cnt equals scoreboard count every cycle; every issue returns exactly once, in order, with the correct owner and tag.
